// File: rtl/nios_with_onchip_sdram_cpu_ocimem_arbiter.sv
// OCI debug-memory arbiter: JTAG monitor commands vs. CPU debug-slave port on one RAM port.
// Optional macro OCIMEM_CPU_WRITE_PROTECT_EN blocks CPU writes at/below PROTECT_TOP outside debug mode.
module nios_with_onchip_sdram_cpu_ocimem_arbiter #(
    parameter int          ADDR_W      = 8,
    parameter int unsigned PROTECT_TOP = 32'h0000_001F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wrdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rddata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] jaddr_r;
    logic              jpend_r;
    logic              jop_wr_r;
    logic [31:0]       jwdata_r;
    logic [31:0]       mon_dreg_r;
    logic [31:0]       cpu_rdata_r;
    logic              overrun_r;
    logic              last_jtag_r;

    logic queue_rd_s;
    logic queue_wr_s;
    logic queue_s;
    logic jtag_busy_s;
    logic accept_s;
    logic cpu_req_s;
    logic grant_j_s;
    logic grant_c_s;
    logic jtag_done_s;
    logic protect_en_s;
    logic protect_hit_s;
    logic cpu_wr_blocked_s;
    logic unused_jdo_s;

    assign queue_rd_s  = (take_action_ocimem_a & jdo[35]) | take_no_action_ocimem_a;
    assign queue_wr_s  = take_action_ocimem_b;
    assign queue_s     = queue_rd_s | queue_wr_s;
    assign jtag_busy_s = jpend_r | (state_r == J_RD);
    assign accept_s    = queue_s & ~jtag_busy_s;
    assign cpu_req_s   = cpu_read | cpu_write;
    // A JTAG op retires either on its write grant or in the read-return cycle.
    assign jtag_done_s = (grant_j_s & jop_wr_r) | (state_r == J_RD);
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
    assign protect_en_s = 1'b1;
`else
    assign protect_en_s = 1'b0;
`endif
    assign protect_hit_s    = (32'(cpu_address) <= PROTECT_TOP);
    assign cpu_wr_blocked_s = protect_en_s & protect_hit_s & ~debugack;

    assign cpu_readdata      = (state_r == C_RD) ? ram_rddata : cpu_rdata_r;
    assign cpu_readdatavalid = (state_r == C_RD);
    assign MonDReg           = mon_dreg_r;
    assign monitor_ready     = ~jpend_r & (state_r != J_RD);
    assign jtag_overrun      = overrun_r;

    // Grant decision, RAM port steering and next state.
    always_comb begin
        state_nxt_s     = state_r;
        grant_j_s       = 1'b0;
        grant_c_s       = 1'b0;
        ram_addr        = cpu_address;
        ram_wrdata      = cpu_writedata;
        ram_we          = 1'b0;
        cpu_waitrequest = cpu_req_s;
        case (state_r)
            IDLE: begin
                // Debug mode or a CPU-last history hands the slot to JTAG.
                if (jpend_r && (debugack || !cpu_req_s || !last_jtag_r)) begin
                    grant_j_s  = 1'b1;
                    ram_addr   = jaddr_r;
                    ram_wrdata = jwdata_r;
                    if (jop_wr_r) begin
                        ram_we      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = J_RD;
                    end
                end else if (cpu_req_s) begin
                    grant_c_s       = 1'b1;
                    cpu_waitrequest = 1'b0;
                    if (cpu_write) begin
                        ram_we      = ~cpu_wr_blocked_s;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = C_RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            J_RD:    state_nxt_s = IDLE;
            C_RD:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, arbitration history and JTAG command bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            jaddr_r     <= '0;
            jpend_r     <= 1'b0;
            jop_wr_r    <= 1'b0;
            jwdata_r    <= 32'd0;
            mon_dreg_r  <= 32'd0;
            cpu_rdata_r <= 32'd0;
            overrun_r   <= 1'b0;
            last_jtag_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if (grant_j_s) begin
                last_jtag_r <= 1'b1;
            end else if (grant_c_s) begin
                last_jtag_r <= 1'b0;
            end else begin
                last_jtag_r <= last_jtag_r;
            end

            // An explicit address load wins over the post-access increment.
            if (take_action_ocimem_a) begin
                jaddr_r <= jdo[17 +: ADDR_W];
            end else if (jtag_done_s) begin
                jaddr_r <= jaddr_r + ADDR_W'(1);
            end else begin
                jaddr_r <= jaddr_r;
            end

            if (accept_s) begin
                jpend_r  <= 1'b1;
                jop_wr_r <= queue_wr_s;
                jwdata_r <= jdo[34:3];
            end else if (jtag_done_s) begin
                jpend_r <= 1'b0;
            end else begin
                jpend_r <= jpend_r;
            end

            if (take_action_ocimem_a) begin
                overrun_r <= 1'b0;
            end else if (queue_s && jtag_busy_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end

            if (state_r == J_RD) begin
                mon_dreg_r <= ram_rddata;
            end else begin
                mon_dreg_r <= mon_dreg_r;
            end

            if (state_r == C_RD) begin
                cpu_rdata_r <= ram_rddata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
        end
    end

endmodule
